y86_execute_stage: RTL and testbench

- Execute-stage sequencer for the Y86-64 datapath. It is the upstream driver of the existing 64-bit ALU (2-bit control: 00 add, 01 sub A-B, 10 and, 11 xor; outputs result and signed-overflow flag).
- Accepts decoded instructions over a valid/ready handshake and maps icode/ifun onto ALU control and operand selection.
- Owns the condition-code register (ZF/SF/OF), evaluates the branch/cmov condition, and registers valE and status toward the memory stage.
- Contains one ALU instance. It is a single-entry output-buffered pipeline stage with a sticky halt/error state machine.

---
 rtl/y86_execute_stage.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_y86_execute_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_execute_stage.sv
// -----------------------------------------------------------------------------
// y86_execute_stage
//
// Execute-stage sequencer for the Y86-64 datapath. Takes one decoded
// instruction bundle per cycle over a valid/ready handshake and maps
// icode/ifun onto the 64-bit ALU's control and operands. It keeps the
// condition-code register (ZF/SF/OF) and evaluates the jXX/cmovXX condition
// against the flags from before the instruction. valE, cnd and the status go
// out through a single-entry registered buffer toward the memory stage.
// A small sticky state machine stops intake after a halt or an invalid
// instruction. Only reset clears it.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid / in_ready   upstream handshake for the decoded bundle
//   icode, ifun           Y86 instruction and function codes
//   valA, valB, valC      register operands and immediate/displacement
//   out_valid / out_ready downstream handshake for the registered result
//   valE                  registered execute result
//   cnd                   registered condition outcome (jXX, cmovXX)
//   out_stat              registered status: 00 AOK, 01 HLT, 10 INS
//   cc_zf, cc_sf, cc_of   current condition-code register
// -----------------------------------------------------------------------------

// 64-bit ALU: 00 add, 01 sub (a - b), 10 and, 11 xor.
// overflow is the two's-complement signed overflow flag. It is 0 for and/xor.
module y86_alu #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   alu_fun,
  output logic [W-1:0] result,
  output logic         overflow
);

  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic [W-1:0] and_bits;
  logic [W-1:0] xor_bits;

  assign sum  = a + b;
  assign diff = a - b;

  // Bitwise logic ops, one slice per bit.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_logic_bit
      assign and_bits[gi] = a[gi] & b[gi];
      assign xor_bits[gi] = a[gi] ^ b[gi];
    end
  endgenerate

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_fun)
      2'b00: begin
        result   = sum;
        // Operands of the same sign that produce a result of the other sign.
        overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      2'b01: begin
        result   = diff;
        // Operands of different signs, and the result's sign differs from a.
        overflow = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      2'b10: result = and_bits;
      default: result = xor_bits;
    endcase
  end

endmodule

module y86_execute_stage #(
  parameter int W          = 64,
  parameter int STACK_STEP = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] valE,
  output logic         cnd,
  output logic [1:0]   out_stat,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] ALU_ADD = 2'b00;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_INS = 2'b10;

  // Stack adjustment as a W-bit two's-complement constant.
  localparam logic [W-1:0] STEP_POS = W'(STACK_STEP);
  localparam logic [W-1:0] STEP_NEG = W'(0) - STEP_POS;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  state_t       state_reg;
  logic         out_valid_reg;
  logic [W-1:0] valE_reg;
  logic         cnd_reg;
  logic [1:0]   stat_reg;
  logic         zf_reg;
  logic         sf_reg;
  logic         of_reg;

  // Decode results
  logic [1:0]   alu_fun;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_result;
  logic         alu_overflow;
  logic         use_alu;
  logic         use_cond;
  logic         set_cc;
  logic         is_halt;
  logic         is_invalid;
  logic         cond_true;

  logic [W-1:0] valE_next;
  logic         cnd_next;
  logic [1:0]   stat_next;

  logic         accept;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign in_ready = (state_reg == ST_RUN) && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Decode icode/ifun to ALU control and operand selection
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_fun    = ALU_ADD;
    alu_a      = '0;
    alu_b      = '0;
    use_alu    = 1'b0;
    use_cond   = 1'b0;
    set_cc     = 1'b0;
    is_halt    = 1'b0;
    is_invalid = 1'b0;
    case (icode)
      I_HALT: is_halt = 1'b1;
      I_NOP:  ;
      I_RRMOVQ: begin
        // cmovXX computes valA. The memory/writeback side uses cnd to
        // decide whether to commit it.
        use_alu    = 1'b1;
        alu_b      = valA;
        use_cond   = 1'b1;
        is_invalid = (ifun > 4'd6);
      end
      I_IRMOVQ: begin
        use_alu = 1'b1;
        alu_b   = valC;
      end
      I_RMMOVQ, I_MRMOVQ: begin
        use_alu = 1'b1;
        alu_a   = valB;
        alu_b   = valC;
      end
      I_OPQ: begin
        if (ifun <= 4'd3) begin
          // B op A ordering: sub yields valB - valA.
          use_alu = 1'b1;
          alu_fun = ifun[1:0];
          alu_a   = valB;
          alu_b   = valA;
          set_cc  = 1'b1;
        end else begin
          is_invalid = 1'b1;
        end
      end
      I_JXX: begin
        use_cond   = 1'b1;
        is_invalid = (ifun > 4'd6);
      end
      I_CALL, I_PUSHQ: begin
        use_alu = 1'b1;
        alu_a   = valB;
        alu_b   = STEP_NEG;
      end
      I_RET, I_POPQ: begin
        use_alu = 1'b1;
        alu_a   = valB;
        alu_b   = STEP_POS;
      end
      default: is_invalid = 1'b1;
    endcase
  end

  y86_alu #(
    .W(W)
  ) u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .alu_fun  (alu_fun),
    .result   (alu_result),
    .overflow (alu_overflow)
  );

  // ---------------------------------------------------------------------------
  // Condition evaluation uses the flags as they stand before this instruction.
  // ---------------------------------------------------------------------------
  always_comb begin
    cond_true = 1'b0;
    case (ifun)
      4'd0: cond_true = 1'b1;
      4'd1: cond_true = (sf_reg ^ of_reg) | zf_reg;
      4'd2: cond_true = sf_reg ^ of_reg;
      4'd3: cond_true = zf_reg;
      4'd4: cond_true = ~zf_reg;
      4'd5: cond_true = ~(sf_reg ^ of_reg);
      4'd6: cond_true = ~(sf_reg ^ of_reg) & ~zf_reg;
      default: cond_true = 1'b0;
    endcase
  end

  // An invalid instruction forces valE and cnd to zero.
  always_comb begin
    valE_next = '0;
    cnd_next  = 1'b0;
    stat_next = STAT_AOK;
    if (is_invalid) begin
      stat_next = STAT_INS;
    end else begin
      if (use_alu)  valE_next = alu_result;
      if (use_cond) cnd_next  = cond_true;
      if (is_halt)  stat_next = STAT_HLT;
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer, condition codes and the sticky run/halt/error state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      out_valid_reg <= 1'b0;
      valE_reg      <= '0;
      cnd_reg       <= 1'b0;
      stat_reg      <= STAT_AOK;
      zf_reg        <= 1'b1;
      sf_reg        <= 1'b0;
      of_reg        <= 1'b0;
    end else begin
      if (accept) begin
        // Buffer is empty or being drained this cycle, so it can be overwritten.
        out_valid_reg <= 1'b1;
        valE_reg      <= valE_next;
        cnd_reg       <= cnd_next;
        stat_reg      <= stat_next;
        if (set_cc) begin
          zf_reg <= (alu_result == '0);
          sf_reg <= alu_result[W-1];
          of_reg <= alu_overflow;
        end
        // accept implies RUN. These transitions leave RUN for good.
        if (is_invalid) begin
          state_reg <= ST_ERR;
        end else if (is_halt) begin
          state_reg <= ST_HALT;
        end
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign valE      = valE_reg;
  assign cnd       = cnd_reg;
  assign out_stat  = stat_reg;
  assign cc_zf     = zf_reg;
  assign cc_sf     = sf_reg;
  assign cc_of     = of_reg;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Directed testbench for y86_execute_stage. Inputs are driven on the falling
// edge, and outputs are sampled on the falling edge after the accepting edge.
module tb_y86_execute_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] valE;
  logic        cnd;
  logic [1:0]  out_stat;
  logic        cc_zf;
  logic        cc_sf;
  logic        cc_of;

  int n_checks = 0;
  int n_pass   = 0;

  y86_execute_stage #(
    .W          (64),
    .STACK_STEP (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .icode     (icode),
    .ifun      (ifun),
    .valA      (valA),
    .valB      (valB),
    .valC      (valC),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .valE      (valE),
    .cnd       (cnd),
    .out_stat  (out_stat),
    .cc_zf     (cc_zf),
    .cc_sf     (cc_sf),
    .cc_of     (cc_of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_cc(input string tag, input logic zf, input logic sf, input logic of_f);
    check(tag, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, zf, sf, of_f});
  endtask

  // Sends one bundle and leaves the bench at the falling edge after it is
  // accepted, when its result is on the outputs.
  task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    @(negedge clk);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    in_valid = 1'b1;
    out_ready = 1'b1;
    check("in_ready_before_send", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("out_valid_after_send", 64'(out_valid), 64'd1);
    $display("txn icode=%h ifun=%h -> valE=%h cnd=%0d stat=%0d cc=%0d%0d%0d",
             ic, fn, valE, cnd, out_stat, cc_zf, cc_sf, cc_of);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0;
    do_reset();

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_valE", valE, 64'd0);
    check("rst_cnd", 64'(cnd), 64'd0);
    check("rst_stat", 64'(out_stat), 64'd0);
    check_cc("rst_cc", 1'b1, 1'b0, 1'b0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // OPq add with signed overflow
    send(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    check("add_valE", valE, 64'h8000_0000_0000_0000);
    check_cc("add_cc", 1'b0, 1'b1, 1'b1);
    check("add_stat", 64'(out_stat), 64'd0);

    // sub to zero, then jle and cmovne
    send(4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
    check("sub_valE", valE, 64'd0);
    check_cc("sub_cc", 1'b1, 1'b0, 1'b0);
    send(4'h7, 4'h1, 64'd0, 64'd0, 64'h40);
    check("jle_cnd", 64'(cnd), 64'd1);
    check("jle_valE", valE, 64'd0);
    send(4'h2, 4'h4, 64'h1234, 64'd0, 64'd0);
    check("cmovne_cnd", 64'(cnd), 64'd0);
    check("cmovne_valE", valE, 64'h1234);

    // and / xor
    send(4'h6, 4'h2, 64'hFF00, 64'hF0F0, 64'd0);
    check("and_valE", valE, 64'hF000);
    check_cc("and_cc", 1'b0, 1'b0, 1'b0);
    send(4'h6, 4'h3, 64'hFF00, 64'hF0F0, 64'd0);
    check("xor_valE", valE, 64'h0FF0);

    // sub with overflow: min_int - 1
    send(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
    check("subov_valE", valE, 64'h7FFF_FFFF_FFFF_FFFF);
    check_cc("subov_cc", 1'b0, 1'b0, 1'b1);
    send(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
    check("jl_cnd", 64'(cnd), 64'd1);
    send(4'h7, 4'h6, 64'd0, 64'd0, 64'd0);
    check("jg_cnd", 64'(cnd), 64'd0);
    send(4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
    check("jge_cnd", 64'(cnd), 64'd0);

    // Stack and address arithmetic, CC untouched
    send(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
    check("push_valE", valE, 64'hF8);
    check_cc("push_cc", 1'b0, 1'b0, 1'b1);
    send(4'hB, 4'h0, 64'd0, 64'hF8, 64'd0);
    check("pop_valE", valE, 64'h100);
    check_cc("pop_cc", 1'b0, 1'b0, 1'b1);
    send(4'h8, 4'h0, 64'd0, 64'h200, 64'd0);
    check("call_valE", valE, 64'h1F8);
    send(4'h9, 4'h0, 64'd0, 64'h1F8, 64'd0);
    check("ret_valE", valE, 64'h200);
    send(4'h3, 4'h0, 64'd0, 64'd0, 64'hDEAD);
    check("irmov_valE", valE, 64'hDEAD);
    send(4'h5, 4'h0, 64'd0, 64'h10, 64'h20);
    check("mrmov_valE", valE, 64'h30);
    send(4'h1, 4'h0, 64'h55, 64'h66, 64'h77);
    check("nop_valE", valE, 64'd0);

    // Backpressure: first bundle held, second waits until out_ready.
    @(negedge clk);
    icode = 4'h3; ifun = 4'h0; valC = 64'h11;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    valC = 64'h22;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_valE_hold", valE, 64'h11);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_valE", valE, 64'h22);
    check("bp_second_valid", 64'(out_valid), 64'd1);
    $display("txn backpressure -> valE=%h", valE);
    @(negedge clk);
    check("bp_drained", 64'(out_valid), 64'd0);
    check("bp_no_dup_valE", valE, 64'h22);

    // halt: status HLT, intake stops, output drains
    send(4'h0, 4'h0, 64'h9, 64'h9, 64'h9);
    check("halt_stat", 64'(out_stat), 64'd1);
    check("halt_valE", valE, 64'd0);
    in_valid = 1'b1; icode = 4'h1;
    for (int i = 0; i < 10; i++) begin
      check("halt_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    check("halt_drained", 64'(out_valid), 64'd0);
    in_valid = 1'b0;

    // Invalid instruction after reset: INS, CC unchanged, sticky
    do_reset();
    check("rst2_in_ready", 64'(in_ready), 64'd1);
    send(4'h6, 4'h0, 64'd1, 64'd1, 64'd0);
    check("add2_valE", valE, 64'd2);
    check_cc("add2_cc", 1'b0, 1'b0, 1'b0);
    send(4'hD, 4'h0, 64'hAAAA, 64'hBBBB, 64'hCCCC);
    check("ins_stat", 64'(out_stat), 64'd2);
    check("ins_valE", valE, 64'd0);
    check("ins_cnd", 64'(cnd), 64'd0);
    check_cc("ins_cc", 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; icode = 4'h1;
    for (int i = 0; i < 4; i++) begin
      check("ins_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Invalid OPq ifun: INS and CC untouched
    do_reset();
    send(4'h6, 4'h4, 64'd1, 64'd0, 64'd0);
    check("opq_ins_stat", 64'(out_stat), 64'd2);
    check_cc("opq_ins_cc", 1'b1, 1'b0, 1'b0);
    check("opq_ins_ready", 64'(in_ready), 64'd0);

    // Reset while stalled
    do_reset();
    send(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    check_cc("pre_rst_cc", 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    icode = 4'h3; ifun = 4'h0; valC = 64'h77;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("stall_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("stall_rst_valid", 64'(out_valid), 64'd0);
    check_cc("stall_rst_cc", 1'b1, 1'b0, 1'b0);
    check("stall_rst_in_ready", 64'(in_ready), 64'd1);
    check("stall_rst_valE", valE, 64'd0);
    send(4'h3, 4'h0, 64'd0, 64'd0, 64'h5A);
    check("post_rst_valE", valE, 64'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
